triple_addsub_serial: RTL
=========================

TRIPLE_ADDSUB_SERIAL -- requirements
Module: triple_addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits processed per cycle; WIDTH mod DIGIT SHALL be 0.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: operands and op are valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 Ports a, b and c, input, WIDTH bits each: the three operands, two's complement.
REQ-008 Port op, input, 2 bits: sign select. 00 gives a+b+c, 10 gives -a+b+c, 01 gives a-b+c, 11 gives a+b-c.
REQ-009 Port out_valid, output, 1 bit: a result is available.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port r, output, WIDTH bits: the result, modulo 2^WIDTH.
REQ-012 Port cout, output, 2 bits: raw carry-out, bits [WIDTH+1:WIDTH] of the internal unsigned sum.
REQ-013 Port ovf, output, 1 bit: signed overflow flag.

Function
REQ-014 Let N = WIDTH/DIGIT.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal 1 only in IDLE.
REQ-017 out_valid SHALL equal 1 only in DONE.
REQ-018 In IDLE, when in_valid=1, the block SHALL capture a, b, c and op on that edge and go to RUN with digit index 0.
REQ-019 On capture, the block SHALL form each operand X' as X, or as ~X if op negates X, and SHALL set the initial carry to 1 when op != 00, else 0.
REQ-020 Each RUN cycle SHALL add digit i of a', b' and c' plus the 2-bit running carry, write DIGIT result bits into r[i*DIGIT +: DIGIT], and keep the new 2-bit carry.
REQ-021 After digit N-1 the FSM SHALL enter DONE, so out_valid rises exactly N cycles after the accepting edge.
REQ-022 In DONE, cout SHALL hold the final running carry.
REQ-023 ovf SHALL be 1 iff the exact signed result of the selected expression lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The MSB-digit sign extension of the operands SHALL be tracked to compute it; negating -2^(WIDTH-1) is exact.
REQ-024 DONE with out_ready=1 SHALL return to IDLE on that edge.
REQ-025 DONE with out_ready=0 SHALL hold r, cout and ovf stable indefinitely.
REQ-026 The minimum issue period SHALL be N+2 cycles; back-to-back in_valid SHALL be accepted at each IDLE.
REQ-027 in_valid seen outside IDLE SHALL be ignored, and inputs changing during RUN SHALL NOT affect the result.
REQ-028 r, cout and ovf SHALL be registered outputs, and their values SHALL be meaningful only while out_valid=1.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set out_valid=0, r=0, cout=00, ovf=0 and clear the digit index, carry and operand registers.
REQ-030 rst_n=0 during RUN or DONE SHALL abort the operation with no result produced, and the first accept after release SHALL proceed normally.

Structure
REQ-031 A shared package SHALL hold the op encodings (OP_ADD=00, OP_NEG_B=01, OP_NEG_A=10, OP_NEG_C=11) and the FSM state enum.
REQ-032 One sub-module, addsub_digit, SHALL be a combinational DIGIT-wide three-operand adder with 2-bit carry in and out, instantiated once.

Verification
REQ-033 The bench SHALL run with WIDTH=8 and DIGIT=4, so N=2, and SHALL cover the following scenarios.
REQ-034 a=0x10, b=0x20, c=0x30, op=00 SHALL give out_valid 2 cycles after accept, r=0x60, ovf=0, cout=00.
REQ-035 a=0x05, b=0x03, c=0x0A, op=11 SHALL give r=0xFE (-2) and ovf=0.
REQ-036 a=0x7F, b=0x7F, c=0x01, op=00 SHALL give r=0xFF and ovf=1.
REQ-037 a=0x80, b=0x00, c=0x00, op=10 SHALL give r=0x80 and ovf=1.
REQ-038 Holding out_ready=0 for 5 cycles in DONE SHALL keep out_valid=1, keep r stable and keep in_ready=0; out_ready=1 SHALL then give IDLE on the next edge.
REQ-039 rst_n=0 for one cycle mid-RUN SHALL give out_valid=0 and in_ready=1 next cycle; a following a=1, b=2, c=3, op=01 SHALL give r=0x02.

Source files
------------

// File: rtl/triple_addsub_serial_pkg.sv
// Shared definitions for the digit-serial three-operand add/subtract unit:
// op encodings, FSM states and the signed-overflow helper.
package triple_addsub_serial_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_NEG_B = 2'b01;
   localparam logic [1:0] OP_NEG_A = 2'b10;
   localparam logic [1:0] OP_NEG_C = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Top three bits of the sign-extended exact sum; any disagreement means
   // the value does not fit in the result width.
   function automatic logic top_overflow(input logic [2:0] top);
      return !((top == 3'b000) || (top == 3'b111));
   endfunction

endpackage

// File: rtl/triple_addsub_serial_addsub_digit.sv
// Combinational DIGIT-wide adder of three operands plus a 2-bit carry.
module addsub_digit
   import triple_addsub_serial_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic [DIGIT-1:0] z,
   input  logic [1:0]       cin,
   output logic [DIGIT-1:0] s,
   output logic [1:0]       cout
);

   // Worst case 3*(2^DIGIT-1)+3 fits in DIGIT+2 bits, so the carry never exceeds 3.
   logic [DIGIT+1:0] sum;

   always_comb begin
      sum  = {2'b00, x} + {2'b00, y} + {2'b00, z} + {{DIGIT{1'b0}}, cin};
      s    = sum[DIGIT-1:0];
      cout = sum[DIGIT+1:DIGIT];
   end

endmodule

// File: rtl/triple_addsub_serial.sv
// Digit-serial a+-b+-c unit: captures operands, adds DIGIT bits per cycle,
// then holds the result with a valid/ready handshake.
module triple_addsub_serial
   import triple_addsub_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic [1:0]       cout,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic [1:0]         cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [DIGIT-1:0]   a_dig, b_dig, c_dig, s_dig;
   logic [1:0]         carry_new;
   logic [1:0]         ext_top;
   logic               last_digit;

   assign a_dig      = a_q[idx_q*DIGIT +: DIGIT];
   assign b_dig      = b_q[idx_q*DIGIT +: DIGIT];
   assign c_dig      = c_q[idx_q*DIGIT +: DIGIT];
   assign last_digit = (idx_q == IDX_W'(N - 1));

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x    (a_dig),
      .y    (b_dig),
      .z    (c_dig),
      .cin  (carry_q),
      .s    (s_dig),
      .cout (carry_new)
   );

   // Bits WIDTH+1:WIDTH of the sign-extended sum: final carry plus the
   // sign-extension words of the (possibly inverted) operands.
   assign ext_top = carry_new + {2{a_q[WIDTH-1]}} + {2{b_q[WIDTH-1]}} + {2{c_q[WIDTH-1]}};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      r_d     = r_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = (op == OP_NEG_A) ? ~a : a;
               b_d     = (op == OP_NEG_B) ? ~b : b;
               c_d     = (op == OP_NEG_C) ? ~c : c;
               carry_d = (op != OP_ADD) ? 2'b01 : 2'b00;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            r_d[idx_q*DIGIT +: DIGIT] = s_dig;
            carry_d = carry_new;
            if (last_digit) begin
               cout_d  = carry_new;
               ovf_d   = top_overflow({ext_top, s_dig[DIGIT-1]});
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         r_q     <= '0;
         cout_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         r_q     <= r_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign r         = r_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
